// File: rtl/piso_frame_tx.sv
// Parallel-in, serial-out framed transmitter.
// Frame on serial_out: start (1), N data bits, optional parity, stop (0). Idle line is low.
// A new word may be accepted during the stop bit, so frames can run back to back.
module piso_frame_tx #(
  parameter int unsigned N          = 4,
  parameter bit          MSB_FIRST  = 1'b0,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         serial_out,
  output logic         busy,
  output logic         frame_done
);

  localparam int unsigned   CntW    = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e          r_state;
  state_e          w_state_d;
  logic [N-1:0]    r_shift;
  logic [N-1:0]    w_shift_d;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_d;
  logic [CntW-1:0] w_idx;
  logic            r_serial;
  logic            w_serial_d;
  logic            w_xfer;

  assign in_ready   = (r_state == StIdle) || (r_state == StStop);
  assign w_xfer     = in_valid && in_ready;
  assign busy       = (r_state != StIdle);
  assign frame_done = (r_state == StStop);
  assign serial_out = r_serial;

  // Bit position of the data bit that goes on the line in the next cycle.
  assign w_idx = MSB_FIRST ? (CntLast - w_cnt_d) : w_cnt_d;

  // Next-state, word latch and bit counter.
  always_comb begin
    w_state_d = r_state;
    w_shift_d = r_shift;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_xfer) begin
          w_state_d = StStart;
          w_shift_d = in_data;
        end
      end
      StStart: begin
        w_state_d = StData;
        w_cnt_d   = '0;
      end
      StData: begin
        if (r_cnt == CntLast) begin
          w_state_d = PARITY_EN ? StParity : StStop;
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end
      StParity: begin
        w_state_d = StStop;
      end
      StStop: begin
        if (w_xfer) begin
          w_state_d = StStart;
          w_shift_d = in_data;
        end else begin
          w_state_d = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // Line value for the upcoming state, so serial_out comes straight from a flop.
  always_comb begin
    w_serial_d = 1'b0;
    unique case (w_state_d)
      StStart:  w_serial_d = 1'b1;
      StData:   w_serial_d = r_shift[w_idx];
      StParity: w_serial_d = (^r_shift) ^ PARITY_ODD;
      default:  w_serial_d = 1'b0;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_serial <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_shift  <= w_shift_d;
      r_cnt    <= w_cnt_d;
      r_serial <= w_serial_d;
    end
  end

endmodule

// File: tb/tb_piso_frame_tx.sv
// Bench for piso_frame_tx: four instances (LSB-first, MSB-first, even parity, odd parity)
// checked every cycle against a line-schedule model: each accepted word appends its whole
// frame to a queue of pending line bits, and one bit is consumed per clock.
module tb_piso_frame_tx;

  logic       clk;
  logic       rst;
  logic [3:0] in_data   [4];
  logic       in_valid  [4];
  logic       in_ready  [4];
  logic       serial_out[4];
  logic       busy      [4];
  logic       frame_done[4];

  // Model state: pending line bits (bit 0 is on the line now) and how many are pending.
  logic [15:0] sched[4];
  int          slen [4];
  logic [15:0] cap  [4];
  bit          xfer [4];

  int n_vec;
  int n_err;

  piso_frame_tx #(.N(4)) u_dut0 (
    .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .serial_out(serial_out[0]), .busy(busy[0]),
    .frame_done(frame_done[0])
  );

  piso_frame_tx #(.N(4), .MSB_FIRST(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .serial_out(serial_out[1]), .busy(busy[1]),
    .frame_done(frame_done[1])
  );

  piso_frame_tx #(.N(4), .PARITY_EN(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .serial_out(serial_out[2]), .busy(busy[2]),
    .frame_done(frame_done[2])
  );

  piso_frame_tx #(.N(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_dut3 (
    .clk(clk), .rst(rst), .in_data(in_data[3]), .in_valid(in_valid[3]),
    .in_ready(in_ready[3]), .serial_out(serial_out[3]), .busy(busy[3]),
    .frame_done(frame_done[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance m: 0 LSB-first, 1 MSB-first, 2 even parity, 3 odd parity.
  function automatic int flen_of(input int m);
    return (m >= 2) ? 7 : 6;
  endfunction

  function automatic logic [15:0] frame_of(input int m, input logic [3:0] d);
    logic [15:0] f;
    f    = '0;
    f[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      f[1 + k] = (m == 1) ? d[3 - k] : d[k];
    end
    if (m >= 2) f[5] = (d[0] ^ d[1] ^ d[2] ^ d[3]) ^ (m == 3);
    return f;
  endfunction

  task automatic chk(input string tag, input int idx, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s dut%0d: observed %0h expected %0h", tag, idx, obs, exp);
    end
  endtask

  // One clock: predict acceptances, advance the model, then compare all outputs.
  task automatic tick();
    for (int i = 0; i < 4; i++) xfer[i] = !rst && in_valid[i] && (slen[i] <= 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        sched[i] = '0;
        slen[i]  = 0;
      end else begin
        if (slen[i] > 0) begin
          sched[i] = sched[i] >> 1;
          slen[i]--;
        end
        if (xfer[i]) begin
          sched[i] = sched[i] | (frame_of(i, in_data[i]) << slen[i]);
          slen[i]  = slen[i] + flen_of(i);
        end
      end
      cap[i] = {cap[i][14:0], serial_out[i]};
      chk("serial_out", i, 16'(serial_out[i]), 16'(sched[i][0]));
      chk("busy",       i, 16'(busy[i]),       16'(slen[i] > 0));
      chk("frame_done", i, 16'(frame_done[i]), 16'(slen[i] == 1));
      chk("in_ready",   i, 16'(in_ready[i]),   16'(slen[i] <= 1));
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data[i]  = '0;
      in_valid[i] = 1'b0;
      sched[i]    = '0;
      slen[i]     = 0;
      cap[i]      = '0;
      xfer[i]     = 1'b0;
    end
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single word 1011 into every variant; 7 captured cycles incl. the trailing idle.
    for (int i = 0; i < 4; i++) begin
      cap[i]      = '0;
      in_data[i]  = 4'b1011;
      in_valid[i] = 1'b1;
    end
    tick();
    for (int i = 0; i < 4; i++) in_valid[i] = 1'b0;
    repeat (6) tick();
    chk("frame_lsb",    0, cap[0], 16'b1110100);
    chk("frame_msb",    1, cap[1], 16'b1101100);
    chk("frame_even_p", 2, cap[2], 16'b1110110);
    chk("frame_odd_p",  3, cap[3], 16'b1110100);

    // Back-to-back: 0001 then 1000 accepted in the stop cycle.
    cap[0]      = '0;
    in_data[0]  = 4'b0001;
    in_valid[0] = 1'b1;
    tick();
    in_data[0] = 4'b1000;
    repeat (6) tick();
    in_valid[0] = 1'b0;
    repeat (5) tick();
    chk("back_to_back", 0, cap[0], 16'b110000100010);

    // 1111 offered mid-frame is held off until the stop bit.
    cap[0]      = '0;
    in_data[0]  = 4'b0101;
    in_valid[0] = 1'b1;
    tick();
    in_data[0] = 4'b1111;
    repeat (6) tick();
    in_valid[0] = 1'b0;
    repeat (5) tick();
    chk("held_off", 0, cap[0], 16'b110100111110);

    // Reset in the third data cycle aborts the frame; the next word is sent whole.
    in_data[0]  = 4'b1011;
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("abort_serial", 0, 16'(serial_out[0]), 16'd0);
    chk("abort_busy",   0, 16'(busy[0]),       16'd0);
    chk("abort_ready",  0, 16'(in_ready[0]),   16'd1);
    rst = 1'b0;
    tick();
    cap[0]      = '0;
    in_data[0]  = 4'b0110;
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    repeat (5) tick();
    chk("after_abort", 0, cap[0], 16'b101100);

    // Random traffic: sources hold a word until the model says it was taken.
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(99) == 0);
      for (int i = 0; i < 4; i++) begin
        if (!in_valid[i] || xfer[i]) begin
          in_valid[i] = 1'($urandom_range(1));
          in_data[i]  = 4'($urandom);
        end
      end
      tick();
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) in_valid[i] = 1'b0;
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
